// File: rtl/spi_pkg.sv
// Shared SPI definitions: default widths, idle fill byte, FSM encoding and mode-0 constants
// used by both this slave and the bridge's SPI master.
package spi_pkg;

  localparam int unsigned DefaultDw = 8;
  localparam logic [DefaultDw-1:0] DefaultDummy = 8'hFF;

  // Mode 0: SCK idles low, data sampled on the leading (rising) edge.
  localparam logic SpiCpol = 1'b0;
  localparam logic SpiCpha = 1'b0;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a third flop for rise/fall detection.
module sync_edge (
  input  logic clk_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Left unreset so a pin already held low through reset never looks like a fresh edge.
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave: oversampled pins, RX byte stream out, TX byte stream in, full duplex.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int unsigned     DW    = DefaultDw,
  parameter logic [DW-1:0]   DUMMY = DefaultDummy
) (
  input  logic          i2c_wb_clk_i,
  input  logic          i2c_wb_rst_i,
  input  logic          sck_i,
  input  logic          mosi_i,
  input  logic          ss_n_i,
  output logic          miso_o,
  output logic          miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          rx_overrun,
  output logic          tx_underrun,
  output logic          busy
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LastBit = CW'(DW - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_sync_q;
  logic sample_edge, shift_edge, load;

  spi_state_e    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic [DW-1:0] tx_buf_q, tx_buf_d;
  logic          tx_full_q, tx_full_d;
  logic          load_pend_q, load_pend_d;
  logic          byte_done_q, byte_done_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          tx_underrun_q, tx_underrun_d;

  sync_edge u_sck_sync (
    .clk_i  (i2c_wb_clk_i),
    .d_i    (sck_i),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  sync_edge u_ss_sync (
    .clk_i  (i2c_wb_clk_i),
    .d_i    (ss_n_i),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  always_ff @(posedge i2c_wb_clk_i) begin
    mosi_meta_q <= mosi_i;
    mosi_sync_q <= mosi_meta_q;
  end

  assign sample_edge = (SpiCpol ^ SpiCpha) ? sck_fall : sck_rise;
  assign shift_edge  = (SpiCpol ^ SpiCpha) ? sck_rise : sck_fall;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    load_pend_d   = load_pend_q;
    byte_done_d   = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    load          = 1'b0;

    case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d     = StActive;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          load        = 1'b1;
        end
      end
      StActive: begin
        // Deselect wins over a coincident SCK edge, so a frame ending on its last fall
        // does not fetch a byte nobody will clock out.
        if (ss_rise) begin
          state_d     = StIdle;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DW-2:0], mosi_sync_q};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d   = '0;
              byte_done_d = 1'b1;
              load_pend_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if (load_pend_q) begin
              load        = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      tx_shift_d    = tx_full_q ? tx_buf_q : DUMMY;
      tx_underrun_d = ~tx_full_q;
    end
    if (tx_valid && !tx_full_q) begin
      tx_buf_d = tx_data;
    end
    tx_full_d = (tx_full_q & ~load) | (tx_valid & ~tx_full_q);

    if (byte_done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      load_pend_q   <= 1'b0;
      byte_done_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      load_pend_q   <= load_pend_d;
      byte_done_q   <= byte_done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign busy        = (state_q == StActive);
  assign miso_oe     = busy;
  assign miso_o      = busy & tx_shift_q[DW-1];
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bus-level master tasks plus a select/RX-stream model.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_slave_responder dut (
    .i2c_wb_clk_i (clk),
    .i2c_wb_rst_i (rst),
    .sck_i        (sck),
    .mosi_i       (mosi),
    .ss_n_i       (ss_n),
    .miso_o       (miso),
    .miso_oe      (miso_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .tx_underrun  (tx_underrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_und = 0;
  int n_ovr = 0;
  int rise_cyc = 0;
  int rxv_cyc = -1;

  logic [7:0] exp_rx[$];
  logic [3:0] ss_hist = 4'hF;
  logic       m_active = 1'b0;
  logic       und_prev = 1'b0, ovr_prev = 1'b0, rxv_prev = 1'b0;
  bit         started = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Select model: a pin edge takes effect three clocks later; reset forces deselected and a
  // select already low at reset release never starts a frame.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
    ss_hist <= {ss_hist[2:0], ss_n};
    if (rst) m_active <= 1'b0;
    else if (ss_hist[2] && !ss_hist[1]) m_active <= 1'b1;
    else if (!ss_hist[2] && ss_hist[1]) m_active <= 1'b0;
  end

  always @(negedge clk) begin
    if (started) begin
      check("miso_oe", int'(miso_oe), int'(m_active));
      check("busy", int'(busy), int'(m_active));
      if (!m_active) check("miso_idle", int'(miso), 0);
      check("underrun_width", int'(tx_underrun && und_prev), 0);
      check("overrun_width", int'(rx_overrun && ovr_prev), 0);
      if (tx_underrun) n_und++;
      if (rx_overrun) n_ovr++;
      if (rx_valid && !rxv_prev) rxv_cyc = cyc;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_extra: got byte %02h, required none (t=%0t)", rx_data, $time);
        end else begin
          check("rx_stream", int'(rx_data), int'(exp_rx.pop_front()));
        end
      end
      und_prev = tx_underrun;
      ovr_prev = rx_overrun;
      rxv_prev = rx_valid;
    end
  end

  task automatic sel();
    @(posedge clk);
    #1 ss_n = 1'b0;
  endtask

  // One byte (or nbits of it) at SCK = clk/8; optionally deselect together with the last fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (4) @(posedge clk);
      #1 sck = 1'b1;
      mi[7-i] = miso;
      rise_cyc = cyc;
      repeat (4) @(posedge clk);
      #1 sck = 1'b0;
      if (last && i == nbits - 1) ss_n = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_ready_timeout: got 0, required 1 within 2000 cycles");
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, int'(miso), 0);
    check({tag, "_miso_oe"}, int'(miso_oe), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tx_ready"}, int'(tx_ready), 1);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_rx_overrun"}, int'(rx_overrun), 0);
    check({tag, "_tx_underrun"}, int'(tx_underrun), 0);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, required test completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [7:0] m0, m1, m2;
    int und0, ovr0;
    logic [7:0] stream_tx[3];
    stream_tx = '{8'h01, 8'h02, 8'h03};

    idle(6);
    check_reset_vals("reset");
    #0 rst = 1'b0;
    idle(6);

    // Single full-duplex byte
    push_tx(8'hA5);
    check("preload_tx_ready", int'(tx_ready), 0);
    und0 = n_und;
    sel();
    idle(3);
    check("start_miso_oe", int'(miso_oe), 1);
    check("start_msb", int'(miso), 1);
    check("start_tx_ready", int'(tx_ready), 1);
    xfer(8'h3C, 8, 1'b1, m0);
    check("single_miso", int'(m0), 'hA5);
    idle(8);
    check("single_rx_data", int'(rx_data), 'h3C);
    check("single_rx_valid", int'(rx_valid), 1);
    check("single_rx_latency", rxv_cyc - rise_cyc, 4);
    check("single_no_underrun", n_und - und0, 0);
    exp_rx.push_back(8'h3C);
    rx_ready = 1'b1;
    idle(2);
    check("single_drained", int'(rx_valid), 0);

    // Underrun: nothing buffered, two-byte frame
    und0 = n_und;
    exp_rx.push_back(8'h81);
    exp_rx.push_back(8'h7E);
    sel();
    xfer(8'h81, 8, 1'b0, m0);
    xfer(8'h7E, 8, 1'b1, m1);
    idle(8);
    check("underrun_byte0", int'(m0), 'hFF);
    check("underrun_byte1", int'(m1), 'hFF);
    check("underrun_pulses", n_und - und0, 2);

    // Overrun: consumer stalled
    rx_ready = 1'b0;
    ovr0 = n_ovr;
    sel();
    xfer(8'h11, 8, 1'b0, m0);
    xfer(8'h22, 8, 1'b1, m1);
    idle(8);
    check("overrun_rx_data", int'(rx_data), 'h11);
    check("overrun_rx_valid", int'(rx_valid), 1);
    check("overrun_pulses", n_ovr - ovr0, 1);
    exp_rx.push_back(8'h11);
    rx_ready = 1'b1;
    idle(2);

    // Back-to-back streaming in one frame
    und0 = n_und;
    ovr0 = n_ovr;
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    exp_rx.push_back(8'h55);
    fork
      begin
        for (int i = 0; i < 3; i++) push_tx(stream_tx[i]);
      end
      begin
        idle(3);
        sel();
        xfer(8'hF0, 8, 1'b0, m0);
        xfer(8'h0F, 8, 1'b0, m1);
        xfer(8'h55, 8, 1'b1, m2);
      end
    join
    idle(8);
    check("stream_miso0", int'(m0), 'h01);
    check("stream_miso1", int'(m1), 'h02);
    check("stream_miso2", int'(m2), 'h03);
    check("stream_no_underrun", n_und - und0, 0);
    check("stream_no_overrun", n_ovr - ovr0, 0);
    check("stream_tx_ready", int'(tx_ready), 1);

    // Abort after 5 bits, then a clean frame
    sel();
    xfer(8'hC3, 5, 1'b1, m0);
    idle(2);
    check("abort_oe_still_on", int'(miso_oe), 1);
    idle(1);
    check("abort_oe_off", int'(miso_oe), 0);
    idle(8);
    check("abort_no_rx_valid", int'(rx_valid), 0);
    exp_rx.push_back(8'h5A);
    sel();
    xfer(8'h5A, 8, 1'b1, m0);
    idle(8);
    check("after_abort_miso", int'(m0), 'hFF);

    // Reset during bit 4 of a frame, with a byte still buffered
    push_tx(8'h77);
    sel();
    push_tx(8'h88);
    xfer(8'hE7, 3, 1'b0, m0);
    check("mid_tx_ready", int'(tx_ready), 0);
    mosi = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(1);
    check_reset_vals("midreset");
    idle(3);
    rst = 1'b0;
    idle(10);
    check("held_select_ignored", int'(busy), 0);
    ss_n = 1'b1;
    idle(6);
    exp_rx.push_back(8'h96);
    sel();
    xfer(8'h96, 8, 1'b1, m0);
    idle(8);
    check("post_reset_miso", int'(m0), 'hFF);
    check("rx_queue_empty", exp_rx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI slave (mode 0, MSB first) that terminates the far end of the bridge's SPI master link (`sck`/`mosi`/`miso`). It oversamples the SPI pins on the system clock and delivers received bytes on a valid/ready stream. In the same full-duplex frame it shifts out bytes supplied on a second valid/ready stream. It serves as the bench/loopback partner for the bridge and as a standalone SPI peripheral front end.

## Interface
- `DW`, 8, shift/word width in bits
- `DUMMY`, 8'hFF, byte transmitted when no TX byte is buffered
- `i2c_wb_clk_i`  in  1  system clock; all logic on rising edge
- `i2c_wb_rst_i`  in  1  reset; synchronous, active-high
- `sck_i`  in  1  SPI clock from master, asynchronous; CPOL=0
- `mosi_i`  in  1  master-out data, asynchronous
- `ss_n_i`  in  1  slave select, active-low, asynchronous
- `miso_o`  out  1  slave-out data
- `miso_oe`  out  1  MISO output enable; 1 only while selected
- `tx_data`  in  DW  next byte to transmit
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  one-deep TX buffer empty
- `rx_data`  out  DW  last received byte
- `rx_valid`  out  1  `rx_data` holds an unread byte
- `rx_ready`  in  1  consumer accepts `rx_data`
- `rx_overrun`  out  1  1-cycle pulse: completed byte dropped
- `tx_underrun`  out  1  1-cycle pulse: `DUMMY` loaded instead of user data
- `busy`  out  1  frame in progress (state ACTIVE)

## Operation
- Each of `sck_i`, `mosi_i` and `ss_n_i` passes through a 2-FF synchronizer. A third register on `sck` and `ss_n` provides edge detection.
- FSM states:
  - IDLE to ACTIVE on synchronized `ss_n` falling edge.
  - ACTIVE to IDLE on synchronized `ss_n` rising edge.
  - Reset forces IDLE.
- On entry to ACTIVE:
  - `bit_cnt` <= 0.
  - TX shift register loads the buffered byte; if the buffer is empty it loads `DUMMY` and pulses `tx_underrun`.
  - `miso_o` = shift MSB.
- Rising `sck` edge (ACTIVE only):
  - rx shift <= {rx_shift[DW-2:0], mosi_sync}.
  - `bit_cnt` increments and wraps at DW-1 to 0.
  - Byte is complete when `bit_cnt` was DW-1.
- Falling `sck` edge (ACTIVE only):
  - If the preceding rising edge completed a byte, reload TX shift from the buffer or `DUMMY` (same underrun rule).
  - Otherwise shift left by one.
- `miso_o` is always the TX shift MSB.
- `miso_oe` = (state == ACTIVE). `miso_o` = 0 in IDLE.
- TX buffer:
  - Write on `tx_valid && tx_ready`.
  - `tx_ready` = buffer empty.
  - A load into the shift register empties the buffer.
  - Write and load in the same cycle: the load takes the old content, the new byte is stored, and `tx_ready` stays 0.
- RX hold, on byte complete:
  - If `rx_valid` is 0, or `rx_ready` is 1 that cycle: `rx_data` <= byte, `rx_valid` <= 1.
  - Otherwise drop the new byte, keep the old one, and pulse `rx_overrun`.
- `rx_valid && rx_ready` with no new byte: `rx_valid` <= 0.
- `ss_n` rises mid-byte: discard the partial RX bits, `bit_cnt` <= 0, no `rx_valid`. An unconsumed TX buffer byte is retained for the next frame.
- `sck` edges while IDLE are ignored.

## Timing
- Reset values:
  - `miso_o`, `miso_oe`, `rx_valid`, `rx_overrun`, `tx_underrun`, `busy` = 0.
  - `tx_ready` = 1.
  - `rx_data` = 0.
  - `bit_cnt` = 0.
- Reset mid-frame aborts immediately. After reset the block waits for a fresh `ss_n` falling edge; a select that is already low is not treated as a frame start.
- Pin-to-edge-detect latency: 3 clocks.
- `miso_oe` and the first MSB are valid 3 clocks after `ss_n` falls.
- Master constraints:
  - SCK high and low phases each ≥ 4 `i2c_wb_clk_i` periods.
  - ss_n-fall to first SCK rise ≥ 4 periods.
- `rx_valid` asserts 1 clock after the edge-detect cycle of the DW-th rising `sck` edge, i.e. 4 clocks after the pin edge.
- Pulses (`rx_overrun`, `tx_underrun`) are exactly 1 clock wide.

## Structure
- Shared package `spi_pkg`:
  - `DW` default.
  - `DUMMY` default.
  - FSM state enum (IDLE, ACTIVE).
  - Mode-0 constants reused by the bridge's SPI master.
- Sub-module `sync_edge` (2-FF synchronizer plus rise/fall detect), instantiated for `sck` and `ss_n`. `mosi` uses the synchronizer only.

## Test plan
- Reset mid-frame:
  - Stimulus: assert reset during bit 4 of a frame.
  - Required: all outputs at reset values next clock; `tx_ready` = 1; after release the next full frame receives correctly.
- Single full-duplex byte:
  - Stimulus: preload tx 8'hA5; master sends 8'h3C at SCK = clk/8.
  - Required: MISO bits 1,0,1,0,0,1,0,1; `rx_data` = 8'h3C, `rx_valid` = 1 four clocks after the 8th rise; `tx_ready` returns to 1 at frame start.
- Underrun:
  - Stimulus: no tx byte, 2-byte frame.
  - Required: MISO = 8'hFF 8'hFF; `tx_underrun` pulses twice.
- Overrun:
  - Stimulus: `rx_ready` = 0; master sends 8'h11 then 8'h22.
  - Required: `rx_data` stays 8'h11; `rx_overrun` pulses once after the 16th rise.
- Back-to-back streaming:
  - Stimulus: tx 8'h01, 8'h02, 8'h03 supplied as `tx_ready` rises; `rx_ready` = 1; master sends 8'hF0, 8'h0F, 8'h55 in one frame.
  - Required: MISO carries 01 02 03; rx stream carries F0 0F 55; no pulses.
- Abort:
  - Stimulus: `ss_n` rises after 5 bits of 8'hC3.
  - Required: no `rx_valid`; `miso_oe` drops 3 clocks later; next frame receives 8'h5A correctly from bit 0.
